// File: rtl/bldc_pkg.sv
// bldc_pkg: shared state encoding, leg bit indices and hall step table for the BLDC sequencer
package bldc_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RAMP  = 3'd1;
  localparam state_t S_RUN   = 3'd2;
  localparam state_t S_DEAD  = 3'd3;
  localparam state_t S_FAULT = 3'd4;
  localparam int LEG_AH = 5;
  localparam int LEG_AL = 4;
  localparam int LEG_BH = 3;
  localparam int LEG_BL = 2;
  localparam int LEG_CH = 1;
  localparam int LEG_CL = 0;
  // Reverse rotation is the forward step with high and low swapped inside each phase pair.
  function automatic logic [5:0] hall_to_legs(input logic [2:0] hall, input logic dir);
    logic [5:0] f;
    f = '0;
    case (hall)
      3'b001: begin f[LEG_AH] = 1'b1; f[LEG_BL] = 1'b1; end
      3'b011: begin f[LEG_AH] = 1'b1; f[LEG_CL] = 1'b1; end
      3'b010: begin f[LEG_BH] = 1'b1; f[LEG_CL] = 1'b1; end
      3'b110: begin f[LEG_BH] = 1'b1; f[LEG_AL] = 1'b1; end
      3'b100: begin f[LEG_CH] = 1'b1; f[LEG_AL] = 1'b1; end
      3'b101: begin f[LEG_CH] = 1'b1; f[LEG_BL] = 1'b1; end
      default: f = '0;
    endcase
    return dir ? {f[LEG_AL], f[LEG_AH], f[LEG_BL], f[LEG_BH], f[LEG_CL], f[LEG_CH]} : f;
  endfunction
endpackage

// File: rtl/bldc_period_timer.sv
// bldc_period_timer: PWM period counter with registered period tick and ramp-rate divider
module bldc_period_timer
  import bldc_pkg::*;
#(
  parameter int PWM_TOP  = 509,
  parameter int RAMP_PER = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic div_clr_i,
  output logic per_tick_o,
  output logic ramp_tick_o
);
  localparam int CW = $clog2(PWM_TOP + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] div_q, div_d;
  logic per_tick_q, per_tick_d;
  // The tick is registered from the next count so it is high exactly while count == PWM_TOP.
  always_comb begin
    cnt_d       = (cnt_q == CW'(PWM_TOP)) ? '0 : cnt_q + 1'b1;
    per_tick_d  = cnt_d == CW'(PWM_TOP);
    ramp_tick_o = per_tick_q && (div_q == 8'(RAMP_PER - 1));
    div_d       = div_clr_i ? 8'd0 : !per_tick_q ? div_q : ramp_tick_o ? 8'd0 : div_q + 8'd1;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      div_q      <= '0;
      per_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      per_tick_q <= per_tick_d;
    end
  end
  assign per_tick_o = per_tick_q;
endmodule

// File: rtl/bldc_commutation_ctrl.sv
// bldc_commutation_ctrl: six-step BLDC sequencer with dead time, duty ramp and fault detection
module bldc_commutation_ctrl
  import bldc_pkg::*;
#(
  parameter int PWM_TOP   = 509,
  parameter int DEAD_CYC  = 16,
  parameter int RAMP_PER  = 4,
  parameter int STALL_CYC = 2000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic       dir_i,
  input  logic [2:0] hall_i,
  input  logic [8:0] duty_tgt_i,
  output logic [8:0] duty_o,
  output logic [5:0] leg_e_o,
  output logic       per_tick_o,
  output logic       fault_o
);
  state_t state_q, state_d, ret_q, ret_d;
  logic [8:0] duty_q, duty_d;
  logic [5:0] legs_q, legs_d;
  logic [2:0] hall_q;
  logic dir_q, dir_d;
  logic [7:0] dead_q, dead_d;
  logic [23:0] stall_q, stall_d;
  logic ramp_tick, hall_ok, hall_chg, dead_done, stall_hit, active_d;
  bldc_period_timer #(.PWM_TOP(PWM_TOP), .RAMP_PER(RAMP_PER)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .div_clr_i  (state_q == S_IDLE),
    .per_tick_o (per_tick_o),
    .ramp_tick_o(ramp_tick)
  );
  assign hall_ok   = hall_i != 3'b000 && hall_i != 3'b111;
  assign hall_chg  = hall_i != hall_q;
  assign dead_done = dead_q == 8'(DEAD_CYC - 1);
  assign stall_hit = stall_q == 24'(STALL_CYC - 1);
  assign active_d  = state_d inside {S_RAMP, S_RUN, S_DEAD};
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // Priority inside a run state: invalid hall, stop, hall change, then per-state progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = !run_i ? S_IDLE : hall_ok ? S_RAMP : S_FAULT;
      S_RAMP, S_RUN, S_DEAD:
        state_d = !hall_ok ? S_FAULT : !run_i ? S_IDLE : hall_chg ? S_DEAD :
                  (state_q == S_DEAD) ? (dead_done ? ret_q : S_DEAD) :
                  (state_q == S_RUN) ? (stall_hit ? S_FAULT : S_RUN) :
                  (per_tick_o && duty_q == duty_tgt_i) ? S_RUN : S_RAMP;
      S_FAULT: state_d = run_i ? S_FAULT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // Step legs track the hall in idle and on every hall change; the output mask applies dead time.
  always_comb begin
    dir_d   = (state_q == S_IDLE) ? dir_i : dir_q;
    legs_d  = (state_q == S_IDLE || hall_chg) ? hall_to_legs(hall_i, dir_d) : legs_q;
    ret_d   = (state_d == S_DEAD && state_q != S_DEAD) ? state_q : ret_q;
    dead_d  = (state_q == S_DEAD && !hall_chg) ? dead_q + 8'd1 : 8'd0;
    stall_d = (state_q == S_RUN && state_d == S_RUN) ? stall_q + 24'd1 : 24'd0;
    duty_d  = !active_d ? 9'd0 : !ramp_tick ? duty_q :
              (duty_q < duty_tgt_i) ? duty_q + 9'd1 :
              (duty_q > duty_tgt_i) ? duty_q - 9'd1 : duty_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ret_q   <= S_IDLE;
      duty_q  <= '0;
      legs_q  <= '0;
      hall_q  <= '0;
      dir_q   <= 1'b0;
      dead_q  <= '0;
      stall_q <= '0;
    end else begin
      ret_q   <= ret_d;
      duty_q  <= duty_d;
      legs_q  <= legs_d;
      hall_q  <= hall_i;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      stall_q <= stall_d;
    end
  end
  always_comb begin
    leg_e_o = (state_q == S_RAMP || state_q == S_RUN) ? legs_q : 6'd0;
    duty_o  = duty_q;
    fault_o = state_q == S_FAULT;
  end
endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// tb_bldc_commutation_ctrl: directed bench with a duty-step scoreboard for bldc_commutation_ctrl
module tb_bldc_commutation_ctrl;
  localparam int PWM_TOP   = 509;
  localparam int DEAD_CYC  = 16;
  localparam int RAMP_PER  = 4;
  localparam int STALL_CYC = 1000;
  localparam int RAMP_GAP  = RAMP_PER * (PWM_TOP + 1);
  typedef struct {
    logic [8:0] v;
    bit         chk;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic [2:0] hall = 3'b001;
  logic [8:0] duty_tgt = 9'd0;
  logic [8:0] duty;
  logic [5:0] legs;
  logic       per_tick;
  logic       fault;
  logic [8:0] prev_duty = 9'd0;
  logic [2:0] seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_chg = 0;
  int         hidx = 0;
  exp_t       sb[$];
  always #5 clk = ~clk;
  bldc_commutation_ctrl #(
    .PWM_TOP(PWM_TOP), .DEAD_CYC(DEAD_CYC), .RAMP_PER(RAMP_PER), .STALL_CYC(STALL_CYC)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .run_i     (run),
    .dir_i     (dir),
    .hall_i    (hall),
    .duty_tgt_i(duty_tgt),
    .duty_o    (duty),
    .leg_e_o   (legs),
    .per_tick_o(per_tick),
    .fault_o   (fault)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Every duty change is matched against the next queued step and, where flagged, its spacing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (duty !== prev_duty) begin
        if (sb.size() == 0) chk("duty_unexpected", 32'(duty), 32'(prev_duty));
        else begin
          e = sb.pop_front();
          chk("duty_step", 32'(duty), 32'(e.v));
          if (e.chk) chk("duty_interval", 32'(cyc - last_chg), 32'(RAMP_GAP));
        end
        prev_duty = duty;
        last_chg = cyc;
      end
    end
  end
  task automatic wait_duty(input logic [8:0] v, input int bound);
    for (int i = 0; i < bound && duty !== v; i++) @(negedge clk);
    chk("wait_duty", 32'(duty), 32'(v));
  endtask
  task automatic wait_legs(input logic [5:0] exp, input string tag);
    int n = 0;
    @(negedge clk);
    while (legs === 6'd0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_dead"}, 32'(n), 32'(DEAD_CYC));
    chk(tag, 32'(legs), 32'(exp));
  endtask
  task automatic commutate(input logic [2:0] h, input logic [5:0] exp, input string tag);
    hall = h;
    wait_legs(exp, tag);
  endtask
  task automatic spin(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i % 400 == 399) begin
        hidx = (hidx + 1) % 6;
        hall = seq[hidx];
      end
    end
  endtask
  initial begin
    int n;
    run = 1'b1;
    dir = 1'b1;
    duty_tgt = 9'd20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_duty", 32'(duty), 0);
    chk("rst_legs", 32'(legs), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_tick", 32'(per_tick), 0);
    run = 1'b0;
    dir = 1'b0;
    duty_tgt = 9'd10;
    rst_n = 1'b1;
    n = 0;
    while (!per_tick && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("tick_first", 32'(n), 32'(PWM_TOP));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!per_tick && n < 600);
    chk("tick_period", 32'(n), 32'(PWM_TOP + 1));
    for (int k = 1; k <= 10; k++) sb.push_back('{9'(k), k > 1});
    run = 1'b1;
    @(negedge clk);
    chk("ramp_legs", 32'(legs), 32'(6'b100100));
    chk("ramp_duty0", 32'(duty), 0);
    wait_duty(9'd10, 25000);
    repeat (520) @(negedge clk);
    commutate(3'b011, 6'b100001, "fwd_011");
    hall = 3'b010;
    repeat (5) @(negedge clk);
    chk("dead_mid", 32'(legs), 0);
    commutate(3'b110, 6'b011000, "fwd_restart_110");
    hidx = 3;
    sb.push_back('{9'd9, 1'b0});
    sb.push_back('{9'd8, 1'b1});
    sb.push_back('{9'd7, 1'b1});
    duty_tgt = 9'd7;
    spin(8200);
    chk("retarget_duty", 32'(duty), 7);
    chk("retarget_nofault", 32'(fault), 0);
    sb.push_back('{9'd0, 1'b0});
    hall = 3'b111;
    @(negedge clk);
    chk("inv_fault", 32'(fault), 1);
    chk("inv_legs", 32'(legs), 0);
    chk("inv_duty", 32'(duty), 0);
    repeat (5) @(negedge clk);
    chk("inv_hold", 32'(fault), 1);
    hall = 3'b001;
    run = 1'b0;
    @(negedge clk);
    chk("inv_clear", 32'(fault), 0);
    chk("inv_clear_legs", 32'(legs), 0);
    duty_tgt = 9'd10;
    for (int k = 1; k <= 10; k++) sb.push_back('{9'(k), k > 1});
    dir = 1'b1;
    run = 1'b1;
    @(negedge clk);
    chk("rev_legs", 32'(legs), 32'(6'b011000));
    dir = 1'b0;
    commutate(3'b011, 6'b010010, "rev_011");
    wait_duty(9'd10, 25000);
    repeat (520) @(negedge clk);
    commutate(3'b010, 6'b000110, "rev_010");
    n = 0;
    repeat (STALL_CYC - 1) begin
      @(negedge clk);
      n += int'(fault);
    end
    chk("stall_pre", 32'(n), 0);
    hall = 3'b110;
    wait_legs(6'b100100, "stall_hall_wins");
    chk("stall_hall_nofault", 32'(fault), 0);
    n = 0;
    repeat (STALL_CYC - 1) begin
      @(negedge clk);
      n += int'(fault);
    end
    chk("stall_pre2", 32'(n), 0);
    sb.push_back('{9'd0, 1'b0});
    @(negedge clk);
    chk("stall_fault", 32'(fault), 1);
    chk("stall_legs", 32'(legs), 0);
    run = 1'b0;
    hall = 3'b001;
    @(negedge clk);
    chk("stall_clear", 32'(fault), 0);
    sb.push_back('{9'd1, 1'b0});
    sb.push_back('{9'd2, 1'b1});
    run = 1'b1;
    wait_duty(9'd2, 12000);
    chk("stop_pre_legs", 32'(legs), 32'(6'b100100));
    sb.push_back('{9'd0, 1'b0});
    run = 1'b0;
    @(negedge clk);
    chk("stop_duty", 32'(duty), 0);
    chk("stop_legs", 32'(legs), 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
